ad_ip_jesd204_tpl_adc_pack: RTL and testbench

// - Downstream of the JESD204 TPL ADC core. Consumes per-channel sample beats (adc_valid/adc_data/enable).
// - Packs only the enabled channels densely into full-width DMA words.
// - Returns adc_dovf to the TPL regmap when a packed word has to be dropped.

---
 rtl/ad_ip_jesd204_tpl_adc_pack_pkg.sv | 20 ++
 rtl/ad_ip_jesd204_tpl_adc_pack_mux.sv | 23 ++
 rtl/ad_ip_jesd204_tpl_adc_pack.sv | 69 ++++++
 tb/tb_ad_ip_jesd204_tpl_adc_pack.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_pack_pkg.sv
// ad_ip_jesd204_tpl_adc_pack_pkg: shared constants and helpers for the TPL ADC packer.
package ad_ip_jesd204_tpl_adc_pack_pkg;

  localparam int SAMPLE_WIDTH = 16;

  function automatic int popcount(input logic [15:0] v);
    popcount = 0;
    for (int i = 0; i < 16; i++) popcount += int'(v[i]);
  endfunction

  function automatic logic is_pow2(input int v);
    return v > 0 && (v & (v - 1)) == 0;
  endfunction

  // Time-major slot order: all enabled channels of sample t before sample t+1.
  function automatic int slot_index(input int t, input int rank, input int e);
    return t * e + rank;
  endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_pack_mux.sv
// ad_ip_jesd204_tpl_adc_pack_mux: compacts one beat of enabled channels into contiguous low slots.
module ad_ip_jesd204_tpl_adc_pack_mux
  import ad_ip_jesd204_tpl_adc_pack_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_PATH_WIDTH = 1,
  localparam int W = NUM_CHANNELS * DATA_PATH_WIDTH * SAMPLE_WIDTH
) (
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic [W-1:0]            data,
  output logic [W-1:0]            compact
);

  always_comb begin
    compact = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      for (int t = 0; t < DATA_PATH_WIDTH; t++)
        if (enable[c])
          compact[slot_index(t, popcount(16'(enable) & ((16'(1) << c) - 16'(1))), popcount(16'(enable))) * SAMPLE_WIDTH +: SAMPLE_WIDTH] =
            data[(c * DATA_PATH_WIDTH + t) * SAMPLE_WIDTH +: SAMPLE_WIDTH];
  end

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_pack.sv
// ad_ip_jesd204_tpl_adc_pack: packs enabled TPL ADC channels densely into full-width DMA words.
module ad_ip_jesd204_tpl_adc_pack
  import ad_ip_jesd204_tpl_adc_pack_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_PATH_WIDTH = 1,
  localparam int W = NUM_CHANNELS * DATA_PATH_WIDTH * SAMPLE_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic [NUM_CHANNELS-1:0] adc_valid,
  input  logic [W-1:0]            adc_data,
  output logic                    adc_dovf,
  output logic                    packed_valid,
  input  logic                    packed_ready,
  output logic [W-1:0]            packed_data,
  output logic                    cfg_error
);

  localparam int CW = $clog2(NUM_CHANNELS) + 1;

  logic [NUM_CHANNELS-1:0] enable_q;
  logic [CW-1:0] beat_cnt;
  logic [W-1:0] acc, compact, word;
  logic changed, accept, last, load, blocked;
  int e;

  ad_ip_jesd204_tpl_adc_pack_mux #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .DATA_PATH_WIDTH(DATA_PATH_WIDTH)
  ) mux (
    .enable(enable_q),
    .data(adc_data),
    .compact(compact)
  );

  // Packing uses the registered mask; the change cycle itself ignores beats.
  assign e = popcount(16'(enable_q));
  assign changed = enable != enable_q;
  assign accept = |(adc_valid & enable_q) && !cfg_error && !changed;
  assign last = (int'(beat_cnt) + 1) * e == NUM_CHANNELS;
  assign word = acc | (compact << (int'(beat_cnt) * e * DATA_PATH_WIDTH * SAMPLE_WIDTH));
  assign load = accept && last;
  assign blocked = packed_valid && !packed_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= '0;
      cfg_error <= 1'b0;
      beat_cnt <= '0;
      acc <= '0;
      packed_valid <= 1'b0;
      packed_data <= '0;
      adc_dovf <= 1'b0;
    end else begin
      enable_q <= enable;
      cfg_error <= !is_pow2(popcount(16'(enable)));
      beat_cnt <= changed || load ? '0 : accept ? beat_cnt + 1'b1 : beat_cnt;
      acc <= changed || load ? '0 : accept ? word : acc;
      adc_dovf <= load && blocked;
      if (load && !blocked) begin
        packed_data <= word;
        packed_valid <= 1'b1;
      end else if (packed_ready) packed_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pack.sv
// tb_ad_ip_jesd204_tpl_adc_pack: directed and random checks against a sample-queue reference model.
module tb_ad_ip_jesd204_tpl_adc_pack;

  localparam int NC = 4;
  localparam int DPW = 1;
  localparam int W = NC * DPW * 16;

  logic clk = 0;
  logic reset;
  logic [NC-1:0] enable, adc_valid;
  logic [W-1:0] adc_data, packed_data;
  logic adc_dovf, packed_valid, packed_ready, cfg_error;

  logic [NC-1:0] m_en;
  logic m_err, m_valid, m_dovf;
  logic [W-1:0] m_data;
  logic [15:0] q[$];
  int vectors = 0;
  int miscompares = 0;

  ad_ip_jesd204_tpl_adc_pack #(.NUM_CHANNELS(NC), .DATA_PATH_WIDTH(DPW)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .adc_valid(adc_valid),
    .adc_data(adc_data),
    .adc_dovf(adc_dovf),
    .packed_valid(packed_valid),
    .packed_ready(packed_ready),
    .packed_data(packed_data),
    .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic full;
    logic [W-1:0] w;
    int n;
    full = 0;
    w = '0;
    if (reset) begin
      m_en = '0; m_err = 0; m_valid = 0; m_data = '0; m_dovf = 0;
      q.delete();
    end else begin
      if (enable != m_en) q.delete();
      else if (!m_err && |(adc_valid & m_en))
        for (int t = 0; t < DPW; t++)
          for (int c = 0; c < NC; c++)
            if (m_en[c]) q.push_back(adc_data[(c * DPW + t) * 16 +: 16]);
      if (q.size() == NC * DPW) begin
        for (int k = 0; k < NC * DPW; k++) w[k * 16 +: 16] = q[k];
        full = 1;
        q.delete();
      end
      m_dovf = full && m_valid && !packed_ready;
      if (full && !m_dovf) begin
        m_data = w;
        m_valid = 1;
      end else if (packed_ready) m_valid = 0;
      n = 0;
      for (int c = 0; c < NC; c++) n += int'(enable[c]);
      m_err = !(n == 1 || n == 2 || n == 4 || n == 8 || n == 16);
      m_en = enable;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("valid", W'(packed_valid), W'(m_valid));
    chk("dovf", W'(adc_dovf), W'(m_dovf));
    chk("cfg_error", W'(cfg_error), W'(m_err));
    chk("data", packed_data, m_data);
  endtask

  task automatic beat(input logic [NC-1:0] v, input int n);
    adc_valid = v;
    for (int c = 0; c < NC; c++) adc_data[c * 16 +: 16] = 16'(32'hC000 | (n << 4) | c);
    tick();
    adc_valid = '0;
  endtask

  task automatic idle();
    adc_valid = '0;
    tick();
  endtask

  task automatic want_word(input string tag, input logic [W-1:0] exp);
    chk({tag, "_valid"}, W'(packed_valid), W'(1));
    chk({tag, "_data"}, packed_data, exp);
  endtask

  initial begin
    reset = 1; enable = '0; adc_valid = '0; adc_data = '0; packed_ready = 1;
    tick();
    tick();
    chk("rst_valid", W'(packed_valid), W'(0));
    chk("rst_data", packed_data, W'(0));
    chk("rst_dovf", W'(adc_dovf), W'(0));
    chk("rst_err", W'(cfg_error), W'(0));
    reset = 0;
    enable = 4'b1111;
    idle();
    beat(4'b1111, 1);
    want_word("all1", 64'hC013_C012_C011_C010);
    beat(4'b1111, 2);
    want_word("all2", 64'hC023_C022_C021_C020);
    beat(4'b1111, 3);
    want_word("all3", 64'hC033_C032_C031_C030);
    chk("all_dovf", W'(adc_dovf), W'(0));
    enable = 4'b0101;
    idle();
    idle();
    beat(4'b0101, 1);
    chk("half_partial", W'(packed_valid), W'(0));
    beat(4'b0101, 2);
    want_word("half", 64'hC022_C020_C012_C010);
    enable = 4'b0001;
    idle();
    idle();
    packed_ready = 0;
    for (int n = 1; n <= 4; n++) beat(4'b0001, n);
    want_word("one_first", 64'hC040_C030_C020_C010);
    for (int n = 5; n <= 7; n++) beat(4'b0001, n);
    chk("one_no_dovf", W'(adc_dovf), W'(0));
    beat(4'b0001, 8);
    chk("one_dovf", W'(adc_dovf), W'(1));
    want_word("one_held", 64'hC040_C030_C020_C010);
    idle();
    chk("one_dovf_pulse", W'(adc_dovf), W'(0));
    packed_ready = 1;
    idle();
    chk("one_drain", W'(packed_valid), W'(0));
    enable = 4'b0011;
    idle();
    idle();
    beat(4'b0011, 5);
    enable = 4'b1100;
    idle();
    idle();
    beat(4'b1100, 1);
    chk("swap_partial", W'(packed_valid), W'(0));
    beat(4'b1100, 2);
    want_word("swap", 64'hC023_C022_C013_C012);
    chk("swap_dovf", W'(adc_dovf), W'(0));
    enable = 4'b0111;
    idle();
    chk("bad_err", W'(cfg_error), W'(1));
    for (int n = 1; n <= 4; n++) beat(4'b0111, n);
    chk("bad_valid", W'(packed_valid), W'(0));
    enable = 4'b1111;
    idle();
    chk("good_err", W'(cfg_error), W'(0));
    beat(4'b1111, 6);
    want_word("resume", 64'hC063_C062_C061_C060);
    enable = 4'b0011;
    idle();
    idle();
    beat(4'b0011, 1);
    reset = 1;
    idle();
    reset = 0;
    chk("rst_mid", W'(packed_valid), W'(0));
    idle();
    beat(4'b0011, 1);
    chk("rst_partial", W'(packed_valid), W'(0));
    beat(4'b0011, 2);
    want_word("rst_word", 64'hC021_C020_C011_C010);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(19) == 0) begin
        case ($urandom_range(11))
          0: enable = 4'b0001;  1: enable = 4'b0010;  2: enable = 4'b0100;
          3: enable = 4'b1000;  4: enable = 4'b0011;  5: enable = 4'b0101;
          6: enable = 4'b1100;  7: enable = 4'b1111;  8: enable = 4'b1010;
          9: enable = 4'b0110;  10: enable = 4'b0111; default: enable = 4'b0000;
        endcase
      end
      reset = $urandom_range(99) == 0;
      adc_valid = NC'($urandom);
      adc_data = {$urandom, $urandom};
      packed_ready = $urandom_range(3) != 0;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
